// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipeline memory stage.
//
// Takes one load or store per request from the M-stage datapath. The pipeline
// is stalled for LATENCY cycles while the access is in flight. Loads return the
// full aligned word; byte and halfword extraction happens in writeback. Stores
// write only the byte lanes selected by size and address. Misaligned,
// out-of-range and illegal-size requests raise a one-cycle error pulse and
// never touch memory.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, 4..4096)
//   LATENCY - cycles from acceptance to response (1..15)
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   memreqM    - request valid, held stable while stallM=1
//   memwriteM  - 1=store, 0=load
//   memsizeM   - 00 byte, 01 half, 10 word, 11 illegal
//   aluoutM    - byte address
//   writedataM - right-justified store data
//   readdataM  - aligned word read, valid in the DONE cycle and held afterwards
//   stallM     - freezes F/D/E/M while high
//   errorM     - one-cycle pulse for a rejected request
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        errorM
);

  localparam int AW = $clog2(DEPTH);
  // The IDLE cycle and the DONE cycle take up two of the LATENCY+1 cycles, so
  // WAIT counts down from LATENCY-2.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lo_q, lo_d;
  logic [1:0]      sz_q, sz_d;
  logic            we_q, we_d;
  logic [31:0]     wd_q, wd_d;
  logic [31:0]     readdata_q, readdata_d;
  logic            error_q, error_d;
  logic            stall_c;

  // Memory contents are deliberately left out of reset so a simulation can
  // preload them.
  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   req_idx;
  logic            req_oor, req_mis, req_ill, req_err;

  assign req_idx = aluoutM[AW+1:2];
  assign req_oor = |aluoutM[31:AW+2];
  assign req_mis = ((memsizeM == 2'b01) && aluoutM[0]) ||
                   ((memsizeM == 2'b10) && (aluoutM[1:0] != 2'b00));
  assign req_ill = (memsizeM == 2'b11);
  assign req_err = req_oor || req_mis || req_ill;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lo_d       = lo_q;
    sz_d       = sz_q;
    we_d       = we_q;
    wd_d       = wd_q;
    readdata_d = readdata_q;
    stall_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memreqM) begin
          if (req_err) begin
            state_d = S_ERR;
          end else begin
            stall_c = 1'b1;
            idx_d   = req_idx;
            lo_d    = aluoutM[1:0];
            sz_d    = memsizeM;
            we_d    = memwriteM;
            wd_d    = writedataM;
            if (LATENCY == 1) begin
              state_d = S_DONE;
              if (!memwriteM) readdata_d = mem_q[req_idx];
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        // A dropped request means the pipeline flushed this instruction.
        if (!memreqM) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) readdata_d = mem_q[idx_q];
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      lo_q       <= 2'b00;
      sz_q       <= 2'b00;
      we_q       <= 1'b0;
      wd_q       <= 32'd0;
      readdata_q <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      sz_q       <= sz_d;
      we_q       <= we_d;
      wd_q       <= wd_d;
      readdata_q <= readdata_d;
      error_q    <= error_d;
    end
  end

  // Lane enables and replicated store data for the captured request.
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wd_q;
    case (sz_q)
      2'b00: begin
        wr_be   = 4'b0001 << lo_q;
        wr_data = {4{wd_q[7:0]}};
      end
      2'b01: begin
        wr_be   = lo_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wd_q[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // The store commits on the edge leaving DONE; an asserted reset blocks it.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_DONE) && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Reset forces stall low at once, even with a request pending in IDLE.
  assign stallM    = stall_c && reset;
  assign readdataM = readdata_q;
  assign errorM    = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req  [2];
  logic        we   [2];
  logic [1:0]  sz   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic        stall[2];
  logic        err  [2];

  int n_cmp = 0;
  int n_err = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .memreqM(req[0]), .memwriteM(we[0]), .memsizeM(sz[0]),
    .aluoutM(addr[0]), .writedataM(wd[0]),
    .readdataM(rd[0]), .stallM(stall[0]), .errorM(err[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .memreqM(req[1]), .memwriteM(we[1]), .memsizeM(sz[1]),
    .aluoutM(addr[1]), .writedataM(wd[1]),
    .readdataM(rd[1]), .stallM(stall[1]), .errorM(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req[sel]  = 1'b1;
    we[sel]   = w;
    sz[sel]   = s;
    addr[sel] = a;
    wd[sel]   = d;
  endtask

  // Legal access: counts stall cycles, then checks the DONE-cycle response.
  // Ends inside the DONE cycle with the request still presented.
  task automatic access(input int sel, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_stalls, input logic [31:0] exp_rd,
                        input string tag);
    int n;
    @(negedge clk);
    drive(sel, w, s, a, d);
    #1;
    n = 0;
    while (stall[sel] && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    chk({tag, "_rd"}, rd[sel], exp_rd);
    chk({tag, "_err"}, 32'(err[sel]), 32'd0);
  endtask

  // Rejected access on the LATENCY=2 instance: no stall, one error pulse.
  task automatic bad_access(input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d,
                            input string tag);
    @(negedge clk);
    drive(0, w, s, a, d);
    #1;
    chk({tag, "_stall0"}, 32'(stall[0]), 32'd0);
    chk({tag, "_err0"}, 32'(err[0]), 32'd0);
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    chk({tag, "_err1"}, 32'(err[0]), 32'd1);
    chk({tag, "_stall1"}, 32'(stall[0]), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_err2"}, 32'(err[0]), 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    req[0] = 1'b0;
    req[1] = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; sz[i] = 2'b00; addr[i] = 32'd0; wd[i] = 32'd0;
    end
    #1;
    chk("rst_rd",    rd[0], 32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    chk("rst_err",   32'(err[0]), 32'd0);
    chk("rst_rd1",   rd[1], 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // Word store then word load, two stall cycles each.
    access(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 2, 32'h0, "t1_st");
    access(0, 1'b0, 2'b10, 32'h10, 32'h0, 2, 32'hDEADBEEF, "t1_ld");

    // Byte and halfword lane merges.
    access(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 2, 32'hDEADBEEF, "t2_stw");
    access(0, 1'b1, 2'b00, 32'h22, 32'h000000AA, 2, 32'hDEADBEEF, "t2_stb");
    access(0, 1'b0, 2'b10, 32'h20, 32'h0, 2, 32'h11AA3344, "t2_ld1");
    access(0, 1'b1, 2'b01, 32'h20, 32'h0000BEEF, 2, 32'h11AA3344, "t2_sth");
    access(0, 1'b0, 2'b10, 32'h20, 32'h0, 2, 32'h11AABEEF, "t2_ld2");
    access(0, 1'b1, 2'b00, 32'h23, 32'h0000007E, 2, 32'h11AABEEF, "t2_stb3");
    access(0, 1'b0, 2'b00, 32'h21, 32'h0, 2, 32'h7EAABEEF, "t2_ld3");

    // Rejected requests leave memory untouched.
    access(0, 1'b1, 2'b10, 32'h04, 32'h01020304, 2, 32'h7EAABEEF, "t3_pre1");
    access(0, 1'b1, 2'b10, 32'h00, 32'hCAFEF00D, 2, 32'h7EAABEEF, "t3_pre2");
    idle();
    bad_access(1'b0, 2'b01, 32'h21, 32'h0, "t3_halfmis");
    bad_access(1'b1, 2'b10, 32'h06, 32'hFFFFFFFF, "t3_wordmis");
    bad_access(1'b1, 2'b11, 32'h00, 32'hFFFFFFFF, "t3_size11");
    access(0, 1'b0, 2'b10, 32'h04, 32'h0, 2, 32'h01020304, "t3_ld1");
    access(0, 1'b0, 2'b10, 32'h00, 32'h0, 2, 32'hCAFEF00D, "t3_ld0");

    // Range boundary: index DEPTH rejected, last word accepted.
    idle();
    bad_access(1'b1, 2'b10, 32'h100, 32'h0BADF00D, "t4_oor");
    access(0, 1'b1, 2'b10, 32'hFC, 32'h12345678, 2, 32'hCAFEF00D, "t4_st");
    access(0, 1'b0, 2'b10, 32'hFC, 32'h0, 2, 32'h12345678, "t4_ld");

    // Flush during WAIT aborts the store.
    access(0, 1'b1, 2'b10, 32'h30, 32'h00000077, 2, 32'h12345678, "t5_pre");
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 32'h30, 32'h00000055);
    #1;
    chk("t5_stall_idle", 32'(stall[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    chk("t5_stall_wait", 32'(stall[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("t5_stall_after", 32'(stall[0]), 32'd0);
    chk("t5_rd_held", rd[0], 32'h12345678);
    access(0, 1'b0, 2'b10, 32'h30, 32'h0, 2, 32'h00000077, "t5_ld");

    // Reset during WAIT: outputs clear at once, store not committed.
    access(0, 1'b1, 2'b10, 32'h40, 32'h00000001, 2, 32'h00000077, "t6_pre");
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 32'h40, 32'h00000099);
    #1;
    chk("t6_stall_idle", 32'(stall[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("t6_stall_wait", 32'(stall[0]), 32'd1);
    reset  = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(stall[0]), 32'd0);
    chk("t6_rst_rd",    rd[0], 32'd0);
    chk("t6_rst_err",   32'(err[0]), 32'd0);
    #1 reset = 1'b1;
    access(0, 1'b0, 2'b10, 32'h40, 32'h0, 2, 32'h00000001, "t6_ld");
    idle();

    // LATENCY=1 instance: one stall cycle per access.
    access(1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1, 32'h0, "t7_st");
    access(1, 1'b0, 2'b10, 32'h10, 32'h0, 1, 32'hDEADBEEF, "t7_ld");
    access(1, 1'b1, 2'b00, 32'h11, 32'h00000042, 1, 32'hDEADBEEF, "t7_stb");
    access(1, 1'b0, 2'b10, 32'h10, 32'h0, 1, 32'hDEAD42EF, "t7_ld2");
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's memory stage.
- Accepts one load/store per request using the address, store data and size that the datapath presents in the M stage.
- Returns the aligned read word for W-stage byte selection, and holds the pipeline with a stall output for a configurable access latency.
- Byte, halfword and word stores are performed by lane; misaligned or out-of-range accesses are reported on an error flag and never touch memory.

Parameters:
DEPTH, 64, number of 32-bit words in the memory array (power of two, 4..4096)
LATENCY, 2, cycles from request acceptance to response (1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
memreqM  input  1  request valid; held stable by the pipeline while stallM=1
memwriteM  input  1  1=store, 0=load
memsizeM  input  2  00 byte, 01 half, 10 word, 11 illegal
aluoutM  input  32  byte address
writedataM  input  32  store data, right-justified (byte in [7:0], half in [15:0])
readdataM  output  32  aligned word read; valid in DONE cycle, held afterwards
stallM  output  1  freeze F/D/E/M stages while high
errorM  output  1  one-cycle pulse: misaligned, out-of-range or illegal size

Behaviour:
- States: IDLE, WAIT, DONE, ERR. All state, counter, captured-request and output registers reset asynchronously when reset=0.
- Reset values: state=IDLE, readdataM=0, errorM=0, stallM=0.
- Memory array contents are not cleared by reset; they are preloadable for simulation.
- Request checks in IDLE, evaluated when memreqM=1:
  - Word index = aluoutM[31:2]; out of range if index >= DEPTH.
  - Misaligned if half with aluoutM[0]=1, or word with aluoutM[1:0]!=00.
  - memsizeM=11 is an error.
- IDLE transitions:
  - memreqM=0: stay; stallM=0.
  - memreqM=1 and error: go to ERR; stallM=0 combinationally; no memory access.
  - memreqM=1 and legal: capture address, data, size and write; stallM=1 combinationally.
  - Legal with LATENCY=1: go to DONE. Otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - stallM=1.
  - Counter decrements each cycle; move to DONE when counter=0.
  - If memreqM falls (pipeline flush), abort: return to IDLE, no write, readdataM unchanged.
- DONE (one cycle):
  - stallM=0.
  - Store: the write commits on the clock edge leaving DONE.
  - Load: readdataM = mem[index], registered on entry to DONE.
  - Always returns to IDLE.
  - The pipeline advances on this cycle, so the next cycle carries a new instruction.
- ERR (one cycle): errorM=1, stallM=0, then IDLE. errorM is registered; its reset value is 0.
- Stall count: a legal access stalls for exactly LATENCY cycles and completes LATENCY+1 cycles after first presentation. Back-to-back requests are accepted in the IDLE cycle following DONE.
- Store lanes:
  - Byte: lane aluoutM[1:0] gets writedataM[7:0].
  - Half: lanes {1,0} or {3,2} per aluoutM[1] get writedataM[15:0].
  - Word: all lanes.
  - Unselected lanes are preserved.
- Load data:
  - The full aligned word is returned regardless of size; byte/half extraction and sign extension happen in writeback.
  - Loads have no side effects.
  - A store's readdataM is unchanged.
- Reset asserted mid-WAIT or mid-DONE: no write commits, state goes to IDLE, stallM=0.

Test Plan:
1. Reset, LATENCY=2; word store 0xDEADBEEF @0x10 then word load @0x10 -> each request stallM high 2 cycles; load DONE readdataM=0xDEADBEEF; store readdataM unchanged.
2. Word 0x11223344 @0x20; byte store 0xAA @0x22; load @0x20 -> readdataM=0x11AA3344. Then half store 0xBEEF @0x20; load -> 0x11AABEEF.
3. Half load @0x21, word store @0x06, size=11 @0x00 -> errorM pulses 1 cycle each, stallM never asserted, memory unchanged.
4. LATENCY=2 store to index DEPTH (@0x100 with DEPTH=64) -> errorM=1; @0xFC succeeds.
5. memreqM dropped during WAIT of store 0x55 @0x30 -> next load @0x30 returns the prior value; stallM falls the cycle after the drop.
6. reset pulsed low during WAIT of a store -> stallM=0, readdataM=0 immediately; the store is not committed. Repeat test 1 with LATENCY=1 -> exactly 1 stall cycle per access.
